// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if
//   Upstream word handshake for uart_tx_param.
//
//   Handshake: a word moves on every rising clk edge where tx_valid && tx_ready
//   are both high. Once tx_valid is raised, the producer keeps tx_valid and
//   tx_data stable until that edge. tx_ready may rise or fall independently of
//   tx_valid. While tx_ready is low, tx_valid is simply ignored.
//
//   Signals:
//     tx_data  [DATA_BITS]  payload word (producer -> transmitter)
//     tx_valid              producer has a word
//     tx_ready              transmitter can take a word this cycle
//   Modports: master = producer side, slave = transmitter side.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param
//   Parametrised UART transmitter. It has an internal baud divider
//   (DIV = CLK_HZ/BAUD clocks per bit), 5..9 data bits sent LSB first,
//   optional odd or even parity, and 1 or 2 stop bits.
//
//   Optional feature: define UART_TX_FIFO_EN to add a FIFO_DEPTH-entry input
//   FIFO between the handshake and the shifter. Without it, a word is taken
//   only while IDLE and fifo_level is tied to 0.
//
//   Ports:
//     clk, rst_n   clock (rising edge), asynchronous active-low reset
//     bus          uart_tx_param_if.slave (tx_data, tx_valid, tx_ready)
//     rs232_tx     serial line, idle high, registered
//     busy         a frame is in progress (state != IDLE)
//     tx_done      one-cycle pulse in the last cycle of the final stop bit
//     fifo_level   FIFO occupancy (0 without UART_TX_FIFO_EN)
//     state_dbg    current FSM state encoding, for observation
module uart_tx_param #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_param_if.slave              bus,
  output logic                        rs232_tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [2:0]                  state_dbg
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  // A PARITY value of 3 is treated the same as 0 (no parity).
  localparam bit PAR_EN = (PARITY == 1) || (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic                 line_d;
  logic                 wrap;
  logic                 ld;
  logic [DATA_BITS-1:0] ld_data;

  assign wrap      = (baud_cnt == DIV_M1);
  assign busy      = (state_q != S_IDLE);
  assign tx_done   = (state_q == S_STOP) && wrap && (bit_cnt == LAST_STOP);
  assign state_dbg = state_q;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr, level;
  logic                 full, empty, push;

  // Pointers carry one extra bit, so their difference is the occupancy.
  assign level        = wr_ptr - rd_ptr;
  assign full         = (level == (AW+1)'(FIFO_DEPTH));
  assign empty        = (level == '0);
  assign bus.tx_ready = rst_n && !full;
  assign push         = bus.tx_valid && bus.tx_ready;
  // The shifter pops while IDLE, or in the tx_done cycle so that the next
  // start bit directly follows the stop bit.
  assign ld           = !empty && ((state_q == S_IDLE) || tx_done);
  assign ld_data      = mem[rd_ptr[AW-1:0]];
  assign fifo_level   = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (ld)   rd_ptr <= rd_ptr + 1'b1;
    end
  end
`else
  assign bus.tx_ready = rst_n && (state_q == S_IDLE);
  assign ld           = bus.tx_valid && bus.tx_ready;
  assign ld_data      = bus.tx_data;
  assign fifo_level   = '0;
`endif

  // Next-state logic. State only advances on a bit boundary (wrap),
  // except for leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ld) state_d = S_START;
      S_START: if (wrap) state_d = S_DATA;
      S_DATA:  if (wrap && (bit_cnt == LAST_DATA)) state_d = PAR_EN ? S_PAR : S_STOP;
      S_PAR:   if (wrap) state_d = S_STOP;
      S_STOP:  if (wrap && (bit_cnt == LAST_STOP)) state_d = ld ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Line level for the current state. It is registered into rs232_tx, so the
  // line trails the state by one clock (accept at edge k -> start bit at k+1).
  always_comb begin
    line_d = 1'b1;
    case (state_q)
      S_START: line_d = 1'b0;
      S_DATA:  line_d = shreg[0];
      S_PAR:   line_d = par_q;
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      rs232_tx <= 1'b1;
    end else begin
      state_q  <= state_d;
      rs232_tx <= line_d;
      // Counter is held at 0 in IDLE, so each frame is phase-aligned to its start.
      if ((state_q == S_IDLE) || wrap) baud_cnt <= '0;
      else                             baud_cnt <= baud_cnt + 1'b1;
      // bit_cnt indexes bits within a multi-bit state (DATA, STOP).
      if (state_d != state_q) bit_cnt <= '0;
      else if (wrap)          bit_cnt <= bit_cnt + 4'd1;
      if (ld) begin
        shreg <= ld_data;
        par_q <= (PARITY == 1) ? ~^ld_data : ^ld_data;
      end else if ((state_q == S_DATA) && wrap) begin
        shreg <= shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

`ifdef UART_TX_FIFO_EN
  localparam bit NOFIFO = 1'b0;
  localparam int LAT    = 3;   // negedges from accept edge until the start bit is seen
`else
  localparam bit NOFIFO = 1'b1;
  localparam int LAT    = 2;
`endif
  localparam int DIVB = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [8:0] exp_q[$];

  logic [8:0] drv_d [4];
  logic       drv_v [4];
  wire  [3:0] tx_w, busy_w, done_w, rdy_w;
  wire  [4:0] lvl0, lvl1, lvl2;
  wire  [2:0] lvl3;
  wire  [2:0] st0, st1, st2, st3;

  uart_tx_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_param_if #(.DATA_BITS(7)) if1 ();
  uart_tx_param_if #(.DATA_BITS(8)) if2 ();
  uart_tx_param_if #(.DATA_BITS(8)) if3 ();

  assign if0.tx_data = drv_d[0][7:0]; assign if0.tx_valid = drv_v[0]; assign rdy_w[0] = if0.tx_ready;
  assign if1.tx_data = drv_d[1][6:0]; assign if1.tx_valid = drv_v[1]; assign rdy_w[1] = if1.tx_ready;
  assign if2.tx_data = drv_d[2][7:0]; assign if2.tx_valid = drv_v[2]; assign rdy_w[2] = if2.tx_ready;
  assign if3.tx_data = drv_d[3][7:0]; assign if3.tx_valid = drv_v[3]; assign rdy_w[3] = if3.tx_ready;

  // 8N1
  uart_tx_param #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .rs232_tx(tx_w[0]), .busy(busy_w[0]),
    .tx_done(done_w[0]), .fifo_level(lvl0), .state_dbg(st0));
  // 7E2
  uart_tx_param #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .rs232_tx(tx_w[1]), .busy(busy_w[1]),
    .tx_done(done_w[1]), .fifo_level(lvl1), .state_dbg(st1));
  // 8O1
  uart_tx_param #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .rs232_tx(tx_w[2]), .busy(busy_w[2]),
    .tx_done(done_w[2]), .fifo_level(lvl2), .state_dbg(st2));
  // 8N1, small FIFO
  uart_tx_param #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(if3), .rs232_tx(tx_w[3]), .busy(busy_w[3]),
    .tx_done(done_w[3]), .fifo_level(lvl3), .state_dbg(st3));

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Offers one word and returns 1 time unit after the accepting edge.
  task automatic send(input int u, input logic [8:0] data);
    int n;
    @(negedge clk);
    drv_d[u] = data;
    drv_v[u] = 1'b1;
    n = 0;
    while (!rdy_w[u] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", (n < 400), 1);
    @(posedge clk);
    #1 drv_v[u] = 1'b0;
    exp_q.push_back(data);
  endtask

  // ---------------- monitor ----------------
  // Waits for a start bit, samples every bit mid-period, checks the frame
  // against the scoreboard head and an independent parity model, and checks
  // tx_done / tx_ready timing relative to the start-bit fall.
  task automatic rx_frame(input int u, input int nbits, input int par, input int nstop,
                          input bit chk_ready, output int wait_n);
    int nb, done_hits, done_at, rdy_bad, bit_i, ones;
    bit seen;
    logic [8:0] word, exp;
    logic pbit, v;
    nb = 1 + nbits + ((par != 0) ? 1 : 0) + nstop;
    wait_n = 0;
    seen = 1'b0;
    while (!seen && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
      if (tx_w[u] === 1'b0) seen = 1'b1;
    end
    chk("start_seen", seen, 1);
    if (!seen) return;
    word = '0; pbit = 1'b0; done_hits = 0; done_at = -1; rdy_bad = 0;
    for (int t = 0; t < nb * DIVB; t++) begin
      if (t > 0) @(negedge clk);
      if (t % DIVB == DIVB / 2) begin
        bit_i = t / DIVB;
        v = tx_w[u];
        if (bit_i == 0) chk("start_bit", v, 0);
        else if (bit_i <= nbits) word[bit_i-1] = v;
        else if (par != 0 && bit_i == nbits + 1) pbit = v;
        else chk("stop_bit", v, 1);
      end
      if (done_w[u] === 1'b1) begin
        done_hits++;
        done_at = t;
      end
      if (chk_ready && (rdy_w[u] !== (t == nb * DIVB - 1))) rdy_bad++;
    end
    chk("tx_done_pulses", done_hits, 1);
    // Line trails the FSM by one clock, so tx_done lands two negedges
    // before the end of the last stop bit as seen on the line.
    chk("tx_done_pos", done_at, nb * DIVB - 2);
    if (chk_ready) chk("ready_during_frame", rdy_bad, 0);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      exp = exp_q.pop_front();
      chk("data_word", word, exp);
      if (par != 0) begin
        ones = $countones(exp);
        chk("parity_bit", pbit, (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1));
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w, accepts, n, done_neg, acc_neg;
    for (int i = 0; i < 4; i++) begin
      drv_d[i] = '0;
      drv_v[i] = 1'b0;
    end
    rst_n = 1'b0;
    #23;
    chk("rst_line", tx_w[0], 1);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_ready", rdy_w[0], 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_level", lvl3, 0);
    chk("rst_state", st0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", rdy_w[0], 1);
    chk("idle_ready_fifo", rdy_w[3], 1);

    // 8N1, 0xA5, with start-bit latency
    send(0, 9'h0A5);
    rx_frame(0, 8, 0, 1, NOFIFO, w);
    chk("latency_a5", w, LAT);

    // 7E2, 0x55 -> even parity bit 0, 176-clock frame
    send(1, 9'h055);
    rx_frame(1, 7, 2, 2, NOFIFO, w);

    // 8O1, 0x00 and 0x01
    send(2, 9'h000);
    rx_frame(2, 8, 1, 1, NOFIFO, w);
    send(2, 9'h001);
    rx_frame(2, 8, 1, 1, NOFIFO, w);

    // random payloads on 8N1 and 7E2
    for (int i = 0; i < 2; i++) begin
      send(0, 9'($urandom_range(0, 255)));
      rx_frame(0, 8, 0, 1, NOFIFO, w);
      send(1, 9'($urandom_range(0, 127)));
      rx_frame(1, 7, 2, 2, NOFIFO, w);
    end

    // reset in the middle of a frame (0x00 keeps the line low at clk 70)
    send(0, 9'h000);
    n = 0;
    while (tx_w[0] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (70) @(negedge clk);
    chk("pre_rst_line_low", tx_w[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_line", tx_w[0], 1);
    chk("midrst_busy", busy_w[0], 0);
    chk("midrst_ready", rdy_w[0], 0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk) rst_n = 1'b1;
    send(0, 9'h03C);
    rx_frame(0, 8, 0, 1, NOFIFO, w);
    chk("latency_3c", w, LAT);

`ifndef UART_TX_FIFO_EN
    // valid held high with changing data: only accepted words go out,
    // second accept one clock after tx_done
    accepts = 0; done_neg = -1; acc_neg = -2;
    fork
      begin
        @(negedge clk);
        drv_d[0] = 9'h05A;
        drv_v[0] = 1'b1;
        n = 0;
        while (accepts < 2 && n < 800) begin
          if (done_w[0] === 1'b1 && accepts == 1) done_neg = n;
          if (rdy_w[0] === 1'b1) begin
            exp_q.push_back(drv_d[0]);
            accepts++;
            if (accepts == 2) acc_neg = n;
          end else begin
            drv_d[0] = 9'($urandom_range(0, 255));
          end
          if (accepts < 2) begin
            @(negedge clk);
            n++;
          end
        end
        @(posedge clk);
        #1 drv_v[0] = 1'b0;
        chk("hold_accepts", accepts, 2);
        chk("accept_after_done", acc_neg, done_neg + 1);
      end
      begin
        rx_frame(0, 8, 0, 1, 1'b1, w);
        rx_frame(0, 8, 0, 1, 1'b1, w);
        chk("b2b_gap", w, 2);
      end
    join
`else
    // FIFO: five back-to-back pushes into a 4-deep FIFO
    fork
      begin
        send(3, 9'h011);
        send(3, 9'h022);
        send(3, 9'h033);
        send(3, 9'h044);
        send(3, 9'h055);
        @(negedge clk);
        chk("fifo_full_ready", rdy_w[3], 0);
        chk("fifo_full_level", lvl3, 4);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          rx_frame(3, 8, 0, 1, 1'b0, w);
          if (i > 0) chk("fifo_zero_gap", w, 1);
        end
      end
    join
    @(negedge clk);
    chk("fifo_level_end", lvl3, 0);
    chk("fifo_busy_end", busy_w[3], 0);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
